// File: rtl/shadow_mismatch_logger.sv
// shadow_mismatch_logger: lockstep comparator between real CPU pins and the
// shadow core's outputs, with a timestamped mismatch trace FIFO drained over a
// valid/ready read port.
// Optional feature: define SHADOW_LOGGER_HALT_EN to add halt_req, which freezes
// logging, counting and the timestamp after the first mismatch.
module shadow_mismatch_logger #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int TS_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic                  CLK_n,
  input  logic                  RESET_n,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      observed,
  input  logic [WIDTH-1:0]      expected,
  input  logic [WIDTH-1:0]      care,
  input  logic                  clear,
  output logic                  match,
  output logic [CNT_W-1:0]      mismatch_count,
  output logic                  overflow,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [TS_W+WIDTH-1:0] rd_data
`ifdef SHADOW_LOGGER_HALT_EN
  ,
  output logic                  halt_req
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = TS_W + WIDTH;

  logic [WIDTH-1:0] diff;
  logic             hit;
  logic             log_hit;
  logic             frozen;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             wr_en;

  logic [TS_W-1:0]  ts_q,     ts_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             match_q,  match_d;
  logic             ovf_q,    ovf_d;
  logic             halt_q,   halt_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  logic [DW-1:0]    mem_q [DEPTH];

  // Compare, FIFO status and all next-state decisions; clear overrides everything.
  always_comb begin
    diff    = (observed ^ expected) & care;
    hit     = enable & (|diff);
`ifdef SHADOW_LOGGER_HALT_EN
    frozen  = halt_q;
`else
    frozen  = 1'b0;
`endif
    log_hit = hit & ~frozen;
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop     = ~empty & rd_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push    = log_hit & (~full | pop);
    wr_en   = push & ~clear;

    ts_d     = ts_q;
    cnt_d    = cnt_q;
    match_d  = match_q;
    ovf_d    = ovf_q;
    halt_d   = halt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (clear) begin
      ts_d     = '0;
      cnt_d    = '0;
      match_d  = 1'b1;
      ovf_d    = 1'b0;
      halt_d   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (enable && !frozen) begin
        ts_d = ts_q + TS_W'(1);
      end
      match_d = ~hit;
      if (log_hit) begin
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!push) begin
          ovf_d = 1'b1;
        end
        halt_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      ts_q     <= '0;
      cnt_q    <= '0;
      match_q  <= 1'b1;
      ovf_q    <= 1'b0;
      halt_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      ts_q     <= ts_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      ovf_q    <= ovf_d;
      halt_q   <= halt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Trace storage: record the pre-increment timestamp with the masked difference.
  always_ff @(posedge CLK_n) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {ts_q, diff};
    end
  end

  assign match          = match_q;
  assign mismatch_count = cnt_q;
  assign overflow       = ovf_q;
  assign rd_valid       = ~empty;
  assign rd_data        = mem_q[rd_ptr_q[AW-1:0]];
`ifdef SHADOW_LOGGER_HALT_EN
  assign halt_req       = halt_q;
`endif

endmodule

// File: tb/tb_shadow_mismatch_logger.sv
// Testbench for shadow_mismatch_logger: directed stimulus pushes expected trace
// entries into a queue; a negedge monitor pops and compares on each read handshake.
module tb_shadow_mismatch_logger;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int TW = 16;
  localparam int CW = 6;
  localparam int DW = TW + W;
  localparam logic [W-1:0] ALL = {W{1'b1}};
  localparam logic [W-1:0] PAT = 32'h1234_5678;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic [W-1:0]  observed = PAT;
  logic [W-1:0]  expected = PAT;
  logic [W-1:0]  care = ALL;
  logic          clear = 1'b0;
  logic          match;
  logic [CW-1:0] mismatch_count;
  logic          overflow;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
`ifdef SHADOW_LOGGER_HALT_EN
  logic          halt_req;
`endif

  logic [DW-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  shadow_mismatch_logger #(.WIDTH(W), .DEPTH(D), .TS_W(TW), .CNT_W(CW)) dut (
    .CLK_n          (clk),
    .RESET_n        (rst_n),
    .enable         (enable),
    .observed       (observed),
    .expected       (expected),
    .care           (care),
    .clear          (clear),
    .match          (match),
    .mismatch_count (mismatch_count),
    .overflow       (overflow),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data)
`ifdef SHADOW_LOGGER_HALT_EN
    ,
    .halt_req       (halt_req)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, wait for the rising edge, settle 1 time unit.
  task automatic cyc(input logic [W-1:0] obs, input logic [W-1:0] ex, input logic [W-1:0] cr,
                     input logic en, input logic clr, input logic rdy);
    observed = obs;
    expected = ex;
    care     = cr;
    enable   = en;
    clear    = clr;
    rd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(PAT, PAT, ALL, 1'b1, 1'b0, rdy);
  endtask

  task automatic expect_entry(input int ts, input logic [W-1:0] d);
    logic [TW-1:0] t;
    t = TW'(ts);
    exp_q.push_back({t, d});
  endtask

  // Monitor: each accepted head entry is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_data: got 0x%0h, expected no entry", rd_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        $display("pop ts=%0d diff=0x%08h", rd_data[DW-1:W], rd_data[W-1:0]);
        check("rd_data", rd_data, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_match", match, 1'b1);
    check("reset_count", mismatch_count, 0);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_overflow", overflow, 1'b0);

`ifdef SHADOW_LOGGER_HALT_EN
    // First mismatch at ts=7 halts logging and freezes the timestamp at 8.
    repeat (7) idle(1'b0);
    expect_entry(7, 32'h0000_00A5);
    cyc(32'h0000_00A5, 32'h0, ALL, 1'b1, 1'b0, 1'b0);
    check("halt_set", halt_req, 1'b1);
    check("halt_count", mismatch_count, 1);
    idle(1'b0);
    cyc(32'h0000_003C, 32'h0, ALL, 1'b1, 1'b0, 1'b0);
    check("halt_count_hold", mismatch_count, 1);
    check("halt_ts_frozen", dut.ts_q, 8);
    idle(1'b1);
    check("halt_single_entry", rd_valid, 1'b0);
    cyc(PAT, PAT, ALL, 1'b1, 1'b1, 1'b0);
    check("halt_released", halt_req, 1'b0);
    expect_entry(0, 32'h1);
    cyc(32'h1, 32'h0, ALL, 1'b1, 1'b0, 1'b0);
    check("halt_reset_again", halt_req, 1'b1);
    idle(1'b1);
`else
    // Matching traffic: nothing logged.
    repeat (5) idle(1'b0);
    check("idle_match", match, 1'b1);
    check("idle_count", mismatch_count, 0);
    check("idle_rd_valid", rd_valid, 1'b0);
    check("idle_overflow", overflow, 1'b0);

    // Single mismatch at ts=5.
    expect_entry(5, 32'h1);
    cyc(32'h1, 32'h0, ALL, 1'b1, 1'b0, 1'b0);
    check("single_match", match, 1'b0);
    check("single_count", mismatch_count, 1);
    check("single_rd_valid", rd_valid, 1'b1);
    idle(1'b1);
    check("single_popped", rd_valid, 1'b0);
    check("single_match_back", match, 1'b1);

    // Difference only in don't-care bits (ts=7).
    cyc(32'hFFFF_0000, 32'h0, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0);
    check("masked_match", match, 1'b1);
    check("masked_count", mismatch_count, 1);
    check("masked_rd_valid", rd_valid, 1'b0);

    // Partial care mask at ts=8: diff = 0xF00FF00F & 0x00FF00FF.
    expect_entry(8, 32'h000F_000F);
    cyc(32'hFF00_FF00, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b1, 1'b0, 1'b0);
    check("partial_count", mismatch_count, 2);
    check("partial_match", match, 1'b0);

    // enable=0: no compare and timestamp holds at 9.
    cyc(32'h0000_DEAD, 32'h0, ALL, 1'b0, 1'b0, 1'b0);
    check("disabled_match", match, 1'b1);
    check("disabled_count", mismatch_count, 2);
    expect_entry(9, 32'h8000_0000);
    cyc(32'h8000_0000, 32'h0, ALL, 1'b1, 1'b0, 1'b0);
    check("ts_hold_count", mismatch_count, 3);
    repeat (2) idle(1'b1);
    check("drain_rd_valid", rd_valid, 1'b0);

    // Fill past capacity: 16 stored (ts 0..15), 4 dropped.
    cyc(PAT, PAT, ALL, 1'b1, 1'b1, 1'b0);
    check("clear_count", mismatch_count, 0);
    for (int i = 0; i < 20; i++) begin
      if (i < D) expect_entry(i, 32'h100 + W'(i));
      cyc(32'h100 + W'(i), 32'h0, ALL, 1'b1, 1'b0, 1'b0);
      if (i == D - 1) begin
        check("full_no_overflow", overflow, 1'b0);
        check("full_count", mismatch_count, 16);
      end
    end
    check("overflow_set", overflow, 1'b1);
    check("overflow_count", mismatch_count, 20);
    check("overflow_rd_valid", rd_valid, 1'b1);
    // Full + pop + push every cycle.
    for (int i = 20; i < 36; i++) begin
      expect_entry(i, 32'h100 + W'(i));
      cyc(32'h100 + W'(i), 32'h0, ALL, 1'b1, 1'b0, 1'b1);
    end
    check("stream_count", mismatch_count, 36);
    check("stream_rd_valid", rd_valid, 1'b1);

    // Clear empties the FIFO and sticky flags.
    exp_q.delete();
    cyc(PAT, PAT, ALL, 1'b1, 1'b1, 1'b0);
    check("clear2_overflow", overflow, 1'b0);
    check("clear2_rd_valid", rd_valid, 1'b0);
    check("clear2_match", match, 1'b1);

    // Full + pop + push without a prior overflow must not raise overflow.
    for (int i = 0; i < 20; i++) begin
      expect_entry(i, 32'h200 + W'(i));
      cyc(32'h200 + W'(i), 32'h0, ALL, 1'b1, 1'b0, (i >= D) ? 1'b1 : 1'b0);
    end
    check("fpp_overflow", overflow, 1'b0);
    check("fpp_count", mismatch_count, 20);
    check("fpp_rd_valid", rd_valid, 1'b1);

    // Clear coinciding with a mismatch while 3 entries are queued.
    exp_q.delete();
    cyc(PAT, PAT, ALL, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(32'h300 + W'(i), 32'h0, ALL, 1'b1, 1'b0, 1'b0);
    end
    check("pre_clear_count", mismatch_count, 3);
    cyc(32'h55, 32'h0, ALL, 1'b1, 1'b1, 1'b0);
    check("clrhit_rd_valid", rd_valid, 1'b0);
    check("clrhit_count", mismatch_count, 0);
    check("clrhit_overflow", overflow, 1'b0);
    check("clrhit_match", match, 1'b1);
    idle(1'b1);
    check("clrhit_still_empty", rd_valid, 1'b0);
    expect_entry(1, 32'h7);
    cyc(32'h7, 32'h0, ALL, 1'b1, 1'b0, 1'b0);
    idle(1'b1);

    // Counter saturation at 2^CW-1 with continuous push/pop.
    cyc(PAT, PAT, ALL, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 70; i++) begin
      expect_entry(i, W'(i + 1));
      cyc(W'(i + 1), 32'h0, ALL, 1'b1, 1'b0, 1'b1);
    end
    check("sat_count", mismatch_count, 63);
    check("sat_overflow", overflow, 1'b0);
    idle(1'b1);
    check("sat_drained", rd_valid, 1'b0);

    // Asynchronous reset mid-cycle discards all state.
    cyc(32'hF0, 32'h0, ALL, 1'b1, 1'b0, 1'b0);
    check("pre_reset_rd_valid", rd_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rd_valid", rd_valid, 1'b0);
    check("async_count", mismatch_count, 0);
    check("async_match", match, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_entry(0, 32'h9);
    cyc(32'h9, 32'h0, ALL, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
